tlb_op_unit: RTL and testbench



---
 rtl/tlb_op_unit_pkg.sv | 51 +++++
 rtl/tlb_op_unit_if.sv | 39 +++
 rtl/tlb_op_unit_fill_idx.sv | 26 ++
 rtl/tlb_op_unit.sv | 170 +++++++++++++++++
 tb/tb_tlb_op_unit.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_op_unit_pkg.sv
// Shared MMU types for the TLB management sequencer: entry layout, op codes,
// FSM states and default table geometry.
package tlb_op_unit_pkg;

  localparam int TLBNUM_DEF   = 16;
  localparam int TLBIDLEN_DEF = 4;

  localparam logic [5:0] ECODE_TLBR = 6'h3f;
  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH,
    S_RD,
    S_WR,
    S_INV,
    S_RESP
  } tlb_op_state_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                    hit;
    logic [TLBIDLEN_DEF-1:0] index;
  } tlb_result_t;

endpackage

// File: rtl/tlb_op_unit_if.sv
// Request/response channel between the CSR stage and the TLB op sequencer.
interface tlb_op_unit_if #(
  parameter int TLBIDLEN = 4
);
  import tlb_op_unit_pkg::*;

  logic                req_valid;
  logic                req_ready;
  tlb_op_t             req_op;
  tlb_entry_t          req_entry;
  logic [TLBIDLEN-1:0] req_index;
  logic                req_ne;
  logic                req_refill;
  logic [18:0]         req_vppn;
  logic [9:0]          req_asid;
  logic [4:0]          req_inv_op;
  logic [9:0]          req_inv_asid;
  logic [31:0]         req_inv_va;
  logic                flush;

  logic                resp_valid;
  logic                resp_hit;
  logic [TLBIDLEN-1:0] resp_index;
  tlb_entry_t          resp_entry;
  logic                resp_inv_err;

  modport master (
    output req_valid, req_op, req_entry, req_index, req_ne, req_refill,
           req_vppn, req_asid, req_inv_op, req_inv_asid, req_inv_va, flush,
    input  req_ready, resp_valid, resp_hit, resp_index, resp_entry, resp_inv_err
  );

  modport slave (
    input  req_valid, req_op, req_entry, req_index, req_ne, req_refill,
           req_vppn, req_asid, req_inv_op, req_inv_asid, req_inv_va, flush,
    output req_ready, resp_valid, resp_hit, resp_index, resp_entry, resp_inv_err
  );

endinterface

// File: rtl/tlb_op_unit_fill_idx.sv
// Free-running FILL replacement index; kept separate so the policy can become
// an LFSR without touching the sequencer.
module tlb_fill_idx #(
  parameter int TLBNUM   = 16,
  parameter int TLBIDLEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [TLBIDLEN-1:0] idx_o
);

  logic [TLBIDLEN-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + TLBIDLEN'(1);
    if (cnt_q == TLBIDLEN'(TLBNUM - 1)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign idx_o = cnt_q;

endmodule

// File: rtl/tlb_op_unit.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB sitting in front of tlb_top;
// one operation in flight, single-beat response back to the CSR stage.
module tlb_op_unit
  import tlb_op_unit_pkg::*;
#(
  parameter int TLBNUM   = TLBNUM_DEF,
  parameter int TLBIDLEN = TLBIDLEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  tlb_op_unit_if.slave        bus,
  output logic                srch_sel_o,
  output logic [18:0]         srch_vppn_o,
  output logic [9:0]          srch_asid_o,
  input  logic                srch_ok_i,
  input  logic                srch_found_i,
  input  logic [TLBIDLEN-1:0] srch_index_i,
  output logic                we_o,
  output logic [TLBIDLEN-1:0] w_index_o,
  output tlb_entry_t          w_entry_o,
  output logic [TLBIDLEN-1:0] r_index_o,
  input  tlb_entry_t          r_entry_i,
  output logic                invtlb_valid_o,
  output logic [4:0]          invtlb_op_o,
  output logic [9:0]          invtlb_asid_o,
  output logic [31:0]         invtlb_va_o
);

  tlb_op_state_t       state_q, state_d;
  tlb_entry_t          entry_q, entry_d;
  logic [TLBIDLEN-1:0] index_q, index_d;
  logic [18:0]         vppn_q, vppn_d;
  logic [9:0]          asid_q, asid_d;
  logic [4:0]          inv_op_q, inv_op_d;
  logic [9:0]          inv_asid_q, inv_asid_d;
  logic [31:0]         inv_va_q, inv_va_d;
  logic                hit_q, hit_d;
  logic [TLBIDLEN-1:0] rindex_q, rindex_d;
  tlb_entry_t          rentry_q, rentry_d;
  logic                inv_err_q, inv_err_d;
  logic [TLBIDLEN-1:0] fill_idx;
  logic                accept;

  tlb_fill_idx #(.TLBNUM(TLBNUM), .TLBIDLEN(TLBIDLEN)) u_fill_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .idx_o (fill_idx)
  );

  assign accept = bus.req_valid & bus.req_ready & ~bus.flush;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    index_d    = index_q;
    vppn_d     = vppn_q;
    asid_d     = asid_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_va_d   = inv_va_q;
    hit_d      = hit_q;
    rindex_d   = rindex_q;
    rentry_d   = rentry_q;
    inv_err_d  = inv_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // FILL resolves its target slot now, so later counter motion is irrelevant
          entry_d    = bus.req_entry;
          entry_d.e  = bus.req_refill | ~bus.req_ne;
          index_d    = (bus.req_op == OP_FILL) ? fill_idx : bus.req_index;
          vppn_d     = bus.req_vppn;
          asid_d     = bus.req_asid;
          inv_op_d   = bus.req_inv_op;
          inv_asid_d = bus.req_inv_asid;
          inv_va_d   = bus.req_inv_va;
          unique case (bus.req_op)
            OP_SRCH:       state_d = S_SRCH;
            OP_RD:         state_d = S_RD;
            OP_WR, OP_FILL: state_d = S_WR;
            OP_INV:        state_d = S_INV;
            default:       state_d = S_IDLE;
          endcase
        end
      end
      S_SRCH: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (srch_ok_i) begin
          hit_d     = srch_found_i;
          rindex_d  = srch_index_i;
          inv_err_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_RD: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          hit_d     = r_entry_i.e;
          rindex_d  = index_q;
          rentry_d  = r_entry_i.e ? r_entry_i : '0;
          inv_err_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_WR: begin
        inv_err_d = 1'b0;
        state_d   = S_RESP;
      end
      S_INV: begin
        inv_err_d = (inv_op_q > INV_OP_MAX);
        state_d   = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      index_q    <= '0;
      vppn_q     <= '0;
      asid_q     <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_va_q   <= '0;
      hit_q      <= 1'b0;
      rindex_q   <= '0;
      rentry_q   <= '0;
      inv_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      index_q    <= index_d;
      vppn_q     <= vppn_d;
      asid_q     <= asid_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_va_q   <= inv_va_d;
      hit_q      <= hit_d;
      rindex_q   <= rindex_d;
      rentry_q   <= rentry_d;
      inv_err_q  <= inv_err_d;
    end
  end

  // Strobes decode registered state only, so reset kills them immediately
  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.resp_valid   = (state_q == S_RESP);
  assign bus.resp_hit     = hit_q;
  assign bus.resp_index   = rindex_q;
  assign bus.resp_entry   = rentry_q;
  assign bus.resp_inv_err = inv_err_q;

  assign srch_sel_o     = (state_q == S_SRCH);
  assign srch_vppn_o    = vppn_q;
  assign srch_asid_o    = asid_q;
  assign we_o           = (state_q == S_WR);
  assign w_index_o      = index_q;
  assign w_entry_o      = entry_q;
  assign r_index_o      = index_q;
  assign invtlb_valid_o = (state_q == S_INV) && (inv_op_q <= INV_OP_MAX);
  assign invtlb_op_o    = inv_op_q;
  assign invtlb_asid_o  = inv_asid_q;
  assign invtlb_va_o    = inv_va_q;

endmodule

// File: tb/tb_tlb_op_unit.sv
// Scoreboard bench for tlb_op_unit: directed ops push expected responses,
// write pulses and invtlb pulses; a negedge monitor pops and compares them.
module tb_tlb_op_unit;
  import tlb_op_unit_pkg::*;

  localparam int TLBNUM   = 16;
  localparam int TLBIDLEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_op_unit_if #(.TLBIDLEN(TLBIDLEN)) bus ();

  logic                srch_sel, srch_ok, srch_found;
  logic [18:0]         srch_vppn;
  logic [9:0]          srch_asid;
  logic [TLBIDLEN-1:0] srch_index;
  logic                we;
  logic [TLBIDLEN-1:0] w_index, r_index;
  tlb_entry_t          w_entry, r_entry;
  logic                invtlb_valid;
  logic [4:0]          invtlb_op;
  logic [9:0]          invtlb_asid;
  logic [31:0]         invtlb_va;

  tlb_op_unit #(.TLBNUM(TLBNUM), .TLBIDLEN(TLBIDLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .srch_sel_o     (srch_sel),
    .srch_vppn_o    (srch_vppn),
    .srch_asid_o    (srch_asid),
    .srch_ok_i      (srch_ok),
    .srch_found_i   (srch_found),
    .srch_index_i   (srch_index),
    .we_o           (we),
    .w_index_o      (w_index),
    .w_entry_o      (w_entry),
    .r_index_o      (r_index),
    .r_entry_i      (r_entry),
    .invtlb_valid_o (invtlb_valid),
    .invtlb_op_o    (invtlb_op),
    .invtlb_asid_o  (invtlb_asid),
    .invtlb_va_o    (invtlb_va)
  );

  typedef struct {
    int                  cyc;
    int                  kind;
    logic                hit;
    logic [TLBIDLEN-1:0] idx;
    tlb_entry_t          ent;
    logic                err;
  } resp_exp_t;

  typedef struct {
    int                  cyc;
    logic [TLBIDLEN-1:0] idx;
    tlb_entry_t          ent;
  } wr_exp_t;

  typedef struct {
    int          cyc;
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [31:0] va;
  } inv_exp_t;

  resp_exp_t respQ[$];
  wr_exp_t   wrQ[$];
  inv_exp_t  invQ[$];

  int nChecks = 0;
  int nPass = 0;
  int cyc;
  int srchSelCnt = 0;
  tlb_entry_t mem [TLBNUM];

  function automatic tlb_entry_t mkEntry(input int s);
    tlb_entry_t t;
    t      = '0;
    t.vppn = 19'(s * 7 + 1);
    t.ps   = 6'd12;
    t.g    = s[0];
    t.asid = 10'(s + 3);
    t.ppn0 = 20'(s * 11 + 2);
    t.plv0 = 2'(s);
    t.mat0 = 2'd1;
    t.d0   = 1'b1;
    t.v0   = 1'b1;
    t.ppn1 = 20'(s * 13 + 5);
    t.plv1 = 2'd3;
    t.mat1 = 2'(s + 1);
    t.v1   = 1'b1;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Behavioural tlb_top table: preloaded with invalid entries on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TLBNUM; i++) mem[i] <= mkEntry(i + 20);
    end else if (we) begin
      mem[w_index] <= w_entry;
    end
  end
  assign r_entry = mem[r_index];

  always @(negedge clk) begin
    if (rst_n) begin
      if (srch_sel) srchSelCnt++;
      if (we || invtlb_valid || bus.resp_valid)
        checkOutput("pulse_exclusive", 128'(int'(we) + int'(invtlb_valid) + int'(bus.resp_valid)), 128'd1);
      if (bus.resp_valid) begin
        checkOutput("resp_expected", 128'(respQ.size() != 0), 128'd1);
        if (respQ.size() != 0) begin
          resp_exp_t e;
          e = respQ.pop_front();
          checkOutput("resp_cycle", 128'(cyc), 128'(e.cyc));
          if (e.kind == 1 || e.kind == 2) begin
            checkOutput("resp_hit", 128'(bus.resp_hit), 128'(e.hit));
            checkOutput("resp_index", 128'(bus.resp_index), 128'(e.idx));
          end
          if (e.kind == 2) checkOutput("resp_entry", 128'(bus.resp_entry), 128'(e.ent));
          if (e.kind == 3) checkOutput("resp_inv_err", 128'(bus.resp_inv_err), 128'(e.err));
        end
      end
      if (we) begin
        checkOutput("we_expected", 128'(wrQ.size() != 0), 128'd1);
        if (wrQ.size() != 0) begin
          wr_exp_t w;
          w = wrQ.pop_front();
          checkOutput("we_cycle", 128'(cyc), 128'(w.cyc));
          checkOutput("w_index", 128'(w_index), 128'(w.idx));
          checkOutput("w_entry", 128'(w_entry), 128'(w.ent));
        end
      end
      if (invtlb_valid) begin
        checkOutput("inv_expected", 128'(invQ.size() != 0), 128'd1);
        if (invQ.size() != 0) begin
          inv_exp_t v;
          v = invQ.pop_front();
          checkOutput("inv_cycle", 128'(cyc), 128'(v.cyc));
          checkOutput("inv_op", 128'(invtlb_op), 128'(v.op));
          checkOutput("inv_asid", 128'(invtlb_asid), 128'(v.asid));
          checkOutput("inv_va", 128'(invtlb_va), 128'(v.va));
        end
      end
    end
  end

  task automatic applyStimulus(input tlb_op_t op, input logic [TLBIDLEN-1:0] idx,
                               input tlb_entry_t ent, input logic ne, input logic refill,
                               input logic [18:0] vppn, input logic [9:0] asid,
                               input logic [4:0] iop, input logic [9:0] iasid,
                               input logic [31:0] iva);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_wait", 128'(guard < 50), 128'd1);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_index    = idx;
    bus.req_entry    = ent;
    bus.req_ne       = ne;
    bus.req_refill   = refill;
    bus.req_vppn     = vppn;
    bus.req_asid     = asid;
    bus.req_inv_op   = iop;
    bus.req_inv_asid = iasid;
    bus.req_inv_va   = iva;
  endtask

  task automatic doWrite(input logic fill, input logic [TLBIDLEN-1:0] idx, input tlb_entry_t ent,
                         input logic ne, input logic refill, input logic flushMid);
    tlb_entry_t expEnt;
    logic [TLBIDLEN-1:0] expIdx;
    applyStimulus(fill ? OP_FILL : OP_WR, idx, ent, ne, refill, '0, '0, '0, '0, '0);
    expEnt   = ent;
    expEnt.e = refill | ~ne;
    expIdx   = fill ? TLBIDLEN'(cyc % TLBNUM) : idx;
    wrQ.push_back('{cyc + 1, expIdx, expEnt});
    respQ.push_back('{cyc + 2, 0, 1'b0, '0, '0, 1'b0});
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (flushMid) bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic doRead(input logic [TLBIDLEN-1:0] idx, input logic expHit, input tlb_entry_t expEnt);
    applyStimulus(OP_RD, idx, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    respQ.push_back('{cyc + 2, 2, expHit, idx, expEnt, 1'b0});
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic doSearch(input int waitCyc, input logic found, input logic [TLBIDLEN-1:0] idx,
                          input logic flushIt);
    applyStimulus(OP_SRCH, '0, '0, 1'b0, 1'b0, 19'h5a5a5, 10'h3c1, '0, '0, '0);
    srchSelCnt = 0;
    if (!flushIt) respQ.push_back('{cyc + 2 + waitCyc, 1, found, idx, '0, 1'b0});
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("srch_vppn", 128'(srch_vppn), 128'h5a5a5);
    checkOutput("srch_asid", 128'(srch_asid), 128'h3c1);
    if (flushIt) begin
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("flush_srch_ready", 128'(bus.req_ready), 128'd1);
      repeat (3) @(negedge clk);
    end else begin
      srch_ok = 1'b0;
      repeat (waitCyc) @(negedge clk);
      srch_ok    = 1'b1;
      srch_found = found;
      srch_index = idx;
      @(negedge clk);
      srch_ok    = 1'b0;
      srch_found = 1'b0;
      srch_index = '0;
      @(negedge clk);
      checkOutput("srch_sel_cycles", 128'(srchSelCnt), 128'(waitCyc + 1));
    end
  endtask

  task automatic doInv(input logic [4:0] op, input logic [9:0] iasid, input logic [31:0] iva);
    applyStimulus(OP_INV, '0, '0, 1'b0, 1'b0, '0, '0, op, iasid, iva);
    if (op <= 5'd6) invQ.push_back('{cyc + 1, op, iasid, iva});
    respQ.push_back('{cyc + 2, 3, 1'b0, '0, '0, (op > 5'd6)});
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tlb_entry_t ex;
    bus.req_valid = 1'b0; bus.req_op = OP_SRCH; bus.req_entry = '0; bus.req_index = '0;
    bus.req_ne = 1'b0; bus.req_refill = 1'b0; bus.req_vppn = '0; bus.req_asid = '0;
    bus.req_inv_op = '0; bus.req_inv_asid = '0; bus.req_inv_va = '0; bus.flush = 1'b0;
    srch_ok = 1'b0; srch_found = 1'b0; srch_index = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 128'(bus.req_ready), 128'd1);
    checkOutput("rst_resp_valid", 128'(bus.resp_valid), 128'd0);
    checkOutput("rst_we", 128'(we), 128'd0);
    checkOutput("rst_invtlb", 128'(invtlb_valid), 128'd0);
    checkOutput("rst_srch_sel", 128'(srch_sel), 128'd0);
    checkOutput("rst_resp_hit", 128'(bus.resp_hit), 128'd0);
    checkOutput("rst_resp_index", 128'(bus.resp_index), 128'd0);
    checkOutput("rst_inv_err", 128'(bus.resp_inv_err), 128'd0);
    checkOutput("rst_w_index", 128'(w_index), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    doWrite(1'b0, 4'd5, mkEntry(1), 1'b0, 1'b0, 1'b0);
    ex = mkEntry(1); ex.e = 1'b1;
    doRead(4'd5, 1'b1, ex);
    doRead(4'd3, 1'b0, '0);
    doWrite(1'b0, 4'd6, mkEntry(2), 1'b1, 1'b0, 1'b0);
    doRead(4'd6, 1'b0, '0);
    doWrite(1'b0, 4'd7, mkEntry(3), 1'b1, 1'b1, 1'b1);
    ex = mkEntry(3); ex.e = 1'b1;
    doRead(4'd7, 1'b1, ex);

    doSearch(1, 1'b1, 4'd9, 1'b0);
    doSearch(0, 1'b0, 4'd2, 1'b0);
    doSearch(3, 1'b1, 4'd15, 1'b0);

    doInv(5'd7, 10'h155, 32'hdead_beef);
    doInv(5'd5, 10'h2aa, 32'h1234_5000);
    doInv(5'd6, 10'h001, 32'hffff_f000);

    doSearch(0, 1'b0, 4'd0, 1'b1);

    bus.req_valid = 1'b1; bus.req_op = OP_WR; bus.req_index = 4'd8; bus.flush = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    checkOutput("flush_idle_ready", 128'(bus.req_ready), 128'd1);
    repeat (3) @(negedge clk);

    for (int i = 0; i < TLBNUM && (cyc % TLBNUM) != TLBNUM - 1; i++) @(negedge clk);
    checkOutput("fill_align", 128'(cyc % TLBNUM), 128'(TLBNUM - 1));
    doWrite(1'b1, 4'd0, mkEntry(4), 1'b1, 1'b1, 1'b0);
    doWrite(1'b1, 4'd0, mkEntry(5), 1'b0, 1'b0, 1'b0);

    applyStimulus(OP_WR, 4'd9, mkEntry(6), 1'b0, 1'b0, '0, '0, '0, '0, '0);
    ex = mkEntry(6); ex.e = 1'b1;
    wrQ.push_back('{cyc + 1, 4'd9, ex});
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_we", 128'(we), 128'd0);
    checkOutput("rstmid_req_ready", 128'(bus.req_ready), 128'd1);
    checkOutput("rstmid_resp_valid", 128'(bus.resp_valid), 128'd0);
    checkOutput("rstmid_w_index", 128'(w_index), 128'd0);
    checkOutput("rstmid_resp_hit", 128'(bus.resp_hit), 128'd0);
    checkOutput("rstmid_inv_err", 128'(bus.resp_inv_err), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    checkOutput("respQ_drained", 128'(respQ.size()), 128'd0);
    checkOutput("wrQ_drained", 128'(wrQ.size()), 128'd0);
    checkOutput("invQ_drained", 128'(invQ.size()), 128'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
